// File: rtl/latched_demux_pkg.sv
// latched_demux_pkg: shared FSM encoding, drop counter width and saturating increment.
package latched_demux_pkg;
    typedef enum logic {IDLE = 1'b0, PASS = 1'b1} state_t;
    localparam int DROP_W = 16;
    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction
endpackage

// File: rtl/latched_demux_if.sv
// latched_demux_if: stream input and per-channel stream outputs of the demux.
interface latched_demux_if #(parameter int WIDTH = 8, parameter int N_OUTPUTS = 3);
    logic [WIDTH-1:0]           s_tdata;
    logic                       s_tvalid;
    logic                       s_tlast;
    logic                       s_tready;
    logic [N_OUTPUTS*WIDTH-1:0] m_tdata;
    logic [N_OUTPUTS-1:0]       m_tvalid;
    logic [N_OUTPUTS-1:0]       m_tlast;
    logic [N_OUTPUTS-1:0]       m_tready;
    modport master (output s_tdata, s_tvalid, s_tlast, m_tready, input s_tready, m_tdata, m_tvalid, m_tlast);
    modport slave (input s_tdata, s_tvalid, s_tlast, m_tready, output s_tready, m_tdata, m_tvalid, m_tlast);
endinterface

// File: rtl/demux_out_reg.sv
// demux_out_reg: single output register shared by all channels, tagged with its channel.
module demux_out_reg #(
    parameter int WIDTH     = 8,
    parameter int N_OUTPUTS = 3,
    parameter int SEL_WIDTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_last,
    input  logic [SEL_WIDTH-1:0]       in_ch,
    input  logic [N_OUTPUTS-1:0]       m_tready,
    output logic                       ready,
    output logic [N_OUTPUTS*WIDTH-1:0] m_tdata,
    output logic [N_OUTPUTS-1:0]       m_tvalid,
    output logic [N_OUTPUTS-1:0]       m_tlast
);
    logic [WIDTH-1:0]       data_q, data_d;
    logic                   last_q, last_d;
    logic                   valid_q, valid_d;
    logic [SEL_WIDTH-1:0]   ch_q, ch_d;
    logic [2**SEL_WIDTH-1:0] rdy_pad;
    always_comb begin
        rdy_pad = '0;
        for (int i = 0; i < N_OUTPUTS; i++) rdy_pad[i] = m_tready[i];
        ready   = ~valid_q | rdy_pad[ch_q];
        valid_d = load | (valid_q & ~rdy_pad[ch_q]);
        data_d  = load ? in_data : data_q;
        last_d  = load ? in_last : last_q;
        ch_d    = load ? in_ch : ch_q;
        m_tdata  = '0;
        m_tvalid = '0;
        m_tlast  = '0;
        for (int i = 0; i < N_OUTPUTS; i++) begin
            m_tdata[i*WIDTH +: WIDTH] = data_q;
            m_tlast[i]  = last_q;
            m_tvalid[i] = valid_q & (ch_q == SEL_WIDTH'(i));
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            ch_q    <= '0;
        end else begin
            data_q  <= data_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
        end
    end
endmodule

// File: rtl/latched_demux.sv
// latched_demux: packet demux whose route is frozen at the first beat from a latched select.
module latched_demux
    import latched_demux_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int N_OUTPUTS = 3,
    parameter int SEL_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clken,
    input  logic [SEL_WIDTH-1:0] sel,
    latched_demux_if.slave       bus,
    output logic [DROP_W-1:0]    drop_count
);
    state_t                 state_q, state_d;
    logic [SEL_WIDTH-1:0]   sel_latched_q, sel_latched_d;
    logic [SEL_WIDTH-1:0]   route_q, route_d;
    logic [DROP_W-1:0]      drop_q, drop_d;
    logic [SEL_WIDTH-1:0]   eff_route;
    logic                   in_range, reg_ready, s_ready, accept, load;
    always_comb begin
        // at a packet boundary the beat follows the pre-edge latched select
        eff_route     = (state_q == IDLE) ? sel_latched_q : route_q;
        in_range      = 32'(eff_route) < N_OUTPUTS;
        s_ready       = in_range ? reg_ready : 1'b1;
        accept        = bus.s_tvalid & s_ready;
        load          = accept & in_range;
        sel_latched_d = clken ? sel : sel_latched_q;
        route_d       = (accept && state_q == IDLE) ? sel_latched_q : route_q;
        state_d       = accept ? (bus.s_tlast ? IDLE : PASS) : state_q;
        drop_d        = (accept & ~in_range & bus.s_tlast) ? sat_inc(drop_q) : drop_q;
    end
    assign bus.s_tready = s_ready;
    assign drop_count   = drop_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            sel_latched_q <= '0;
            route_q       <= '0;
            drop_q        <= '0;
        end else begin
            state_q       <= state_d;
            sel_latched_q <= sel_latched_d;
            route_q       <= route_d;
            drop_q        <= drop_d;
        end
    end
    demux_out_reg #(.WIDTH(WIDTH), .N_OUTPUTS(N_OUTPUTS), .SEL_WIDTH(SEL_WIDTH)) u_out (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .in_data  (bus.s_tdata),
        .in_last  (bus.s_tlast),
        .in_ch    (eff_route),
        .m_tready (bus.m_tready),
        .ready    (reg_ready),
        .m_tdata  (bus.m_tdata),
        .m_tvalid (bus.m_tvalid),
        .m_tlast  (bus.m_tlast)
    );
endmodule

// File: tb/tb_latched_demux.sv
// tb_latched_demux: directed and random stimulus checked against a packet-level reference model.
module tb_latched_demux;
    logic        clk = 1'b0;
    logic        rst;
    logic        clken;
    logic [1:0]  sel;
    logic [15:0] drop_count;
    int          checks = 0;
    int          failures = 0;
    int          m_sel, m_route, m_pch, m_drop;
    bit          m_inpkt, m_pv, m_plast, acc;
    logic [7:0]  m_pdata;
    latched_demux_if #(.WIDTH(8), .N_OUTPUTS(3)) bus ();
    latched_demux #(.WIDTH(8), .N_OUTPUTS(3), .SEL_WIDTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .clken      (clken),
        .sel        (sel),
        .bus        (bus.slave),
        .drop_count (drop_count)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_sel = 0; m_route = 0; m_pch = 0; m_drop = 0;
        m_inpkt = 0; m_pv = 0; m_plast = 0; m_pdata = '0;
    endtask
    // one clock: check outputs against the model, then advance the model at the edge
    task automatic cycle();
        int  e;
        bit  inr, rdy, drained;
        e   = m_inpkt ? m_route : m_sel;
        inr = e < 3;
        rdy = !inr || !m_pv || bus.m_tready[m_pch];
        #1;
        chk("s_tready", 32'(bus.s_tready), 32'(rdy));
        chk("m_tvalid", 32'(bus.m_tvalid), m_pv ? (32'd1 << m_pch) : 32'd0);
        chk("m_tdata", 32'(bus.m_tdata), 32'({3{m_pdata}}));
        chk("m_tlast", 32'(bus.m_tlast), m_plast ? 32'h7 : 32'h0);
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        acc = bus.s_tvalid && rdy;
        @(posedge clk);
        drained = m_pv && bus.m_tready[m_pch];
        if (acc && inr) begin
            m_pv = 1; m_pch = e; m_pdata = bus.s_tdata; m_plast = bus.s_tlast;
        end else if (drained) m_pv = 0;
        if (acc && !inr && bus.s_tlast && m_drop < 65535) m_drop++;
        if (acc) begin
            if (!m_inpkt && !bus.s_tlast) begin m_inpkt = 1; m_route = e; end
            else if (m_inpkt && bus.s_tlast) m_inpkt = 0;
        end
        if (clken) m_sel = int'(sel);
        @(negedge clk);
    endtask
    task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit ce, input logic [1:0] s, input logic [2:0] r);
        bus.s_tvalid = v; bus.s_tdata = d; bus.s_tlast = l;
        clken = ce; sel = s; bus.m_tready = r;
        cycle();
    endtask
    task automatic send_pkt(input int n, input logic [7:0] base);
        for (int b = 0; b < n; b++) begin
            int tries = 0;
            do begin
                drive(1, 8'(base + b), b == n - 1, 0, 0, 3'b111);
                tries++;
            end while (!acc && tries < 20);
            if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
        end
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 8'h00, 0, 0, 0, 3'b111);
    endtask
    initial begin
        int b;
        rst = 1; clken = 0; sel = 0;
        bus.s_tvalid = 0; bus.s_tdata = 0; bus.s_tlast = 0; bus.m_tready = 3'b111;
        model_reset();
        #2;
        chk("rst_s_tready", 32'(bus.s_tready), 32'd1);
        chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        // 4-beat packet to channel 1
        drive(0, 8'h00, 0, 1, 2'd1, 3'b111);
        send_pkt(4, 8'h10);
        idle(2);
        // select change mid-packet applies to the next packet only
        drive(1, 8'h20, 0, 0, 0, 3'b111);
        drive(1, 8'h21, 0, 1, 2'd2, 3'b111);
        send_pkt(2, 8'h22);
        send_pkt(2, 8'h30);
        idle(2);
        // out-of-range route: two dropped packets
        drive(0, 8'h00, 0, 1, 2'd3, 3'b111);
        send_pkt(3, 8'hA0);
        send_pkt(3, 8'hB0);
        idle(1);
        chk("drop_after_two", 32'(drop_count), 32'd2);
        // backpressure on channel 1 for 5 cycles
        drive(0, 8'h00, 0, 1, 2'd1, 3'b111);
        b = 0;
        for (int c = 0; c < 30 && b < 4; c++) begin
            drive(1, 8'(8'h40 + b), b == 3, 0, 0, (c >= 1 && c < 6) ? 3'b101 : 3'b111);
            if (acc) b++;
        end
        chk("stall_beats", 32'(b), 32'd4);
        idle(2);
        // single-beat packets with select toggling every cycle
        for (int i = 0; i < 6; i++) drive(1, 8'(8'h70 + i), 1, 1, (i % 2) ? 2'd2 : 2'd0, 3'b111);
        idle(2);
        // asynchronous reset during beat 2 of a packet
        drive(0, 8'h00, 0, 1, 2'd2, 3'b111);
        drive(1, 8'h50, 0, 0, 0, 3'b111);
        bus.s_tvalid = 1; bus.s_tdata = 8'h51; bus.s_tlast = 0;
        #2 rst = 1;
        #1;
        chk("arst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
        chk("arst_s_tready", 32'(bus.s_tready), 32'd1);
        chk("arst_m_tdata", 32'(bus.m_tdata), 32'd0);
        chk("arst_drop", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst = 0;
        model_reset();
        send_pkt(2, 8'h60);
        #1 chk("post_rst_ch0", 32'(bus.m_tvalid), 32'd1);
        @(negedge clk);
        idle(2);
        // random traffic
        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 3,
                  $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                  3'($urandom) | (($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000));
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/latched_demux.md
LATCHED_DEMUX -- requirements
Module: latched_demux

Interface
REQ-001 Parameter WIDTH, default 8, data beat width in bits.
REQ-002 Parameter N_OUTPUTS, default 3, number of output channels.
REQ-003 Parameter SEL_WIDTH, default 2, select width; SHALL satisfy 2**SEL_WIDTH >= N_OUTPUTS.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 clken  in  1  select latch enable.
REQ-007 sel  in  SEL_WIDTH  requested output channel.
REQ-008 s_tdata  in  WIDTH  input beat data.
REQ-009 s_tvalid  in  1  input beat valid.
REQ-010 s_tlast  in  1  last beat of packet.
REQ-011 s_tready  out  1  input beat accepted when s_tvalid & s_tready.
REQ-012 m_tdata  out  N_OUTPUTS*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-013 m_tvalid  out  N_OUTPUTS  per-channel valid.
REQ-014 m_tlast  out  N_OUTPUTS  per-channel last.
REQ-015 m_tready  in  N_OUTPUTS  per-channel ready.
REQ-016 drop_count  out  16  packets discarded due to out-of-range select, saturating.

Function
REQ-017 sel_latched SHALL load sel at each rising edge with clken=1; hold otherwise.
REQ-018 FSM states IDLE (packet boundary) and PASS (inside packet).
REQ-019 In IDLE, on first-beat acceptance, route SHALL load sel_latched's pre-edge value; route frozen in PASS.
REQ-020 IDLE->PASS on accepted beat with s_tlast=0; PASS->IDLE on accepted beat with s_tlast=1; single-beat packet stays IDLE.
REQ-021 Changes to sel/sel_latched mid-packet SHALL NOT affect the current packet.
REQ-022 Single output register (data, last, ch, valid) shared by all channels; ch captured with each beat.
REQ-023 Latency: beat accepted at edge k visible on m_* after edge k (1 cycle).
REQ-024 m_tdata/m_tlast slices SHALL all carry register contents; m_tvalid[i] = out_valid & (out_ch == i).
REQ-025 s_tready = ~out_valid | m_tready[out_ch] for in-range route; full throughput of 1 beat/cycle when downstream ready.
REQ-026 Register SHALL load on acceptance, clear valid when drained with no new acceptance, hold when m_tready[out_ch]=0.
REQ-027 Route >= N_OUTPUTS: s_tready=1, beats discarded, no m_tvalid asserted; drop_count +1 on accepted tlast beat, saturates at 16'hFFFF.
REQ-028 Pending beat of prior packet SHALL drain to its captured ch even if the new packet routes elsewhere; new beat accepted only per REQ-025 (single register, no reordering).
REQ-029 Simultaneous clken and first beat: the first beat uses the old sel_latched; the new value applies to the next packet.

Reset
REQ-030 rst=1 SHALL asynchronously force: sel_latched=0, route=0, FSM=IDLE, out_valid=0, out_data=0, out_last=0, out_ch=0, drop_count=0.
REQ-031 Reset mid-packet SHALL discard the packet remainder and pending beat; after deassertion, the next accepted beat is a first beat.
REQ-032 During reset m_tvalid=0 and s_tready=1.

Structure
REQ-033 Shared package latched_demux_pkg SHALL hold FSM state encoding (IDLE=0, PASS=1) and drop_count width constant (16).
REQ-034 Output register in one sub-module demux_out_reg (data, last, ch, valid, ready logic); FSM, select latch and drop counter in top.

Verification
REQ-035 WIDTH=8, N_OUTPUTS=3: clken=1 sel=1 one cycle, then 4-beat packet 0x10..0x13 -> m_tvalid=3'b010, data 0x10..0x13, m_tlast[1] on 0x13, one beat per cycle.
REQ-036 Mid-packet clken=1 sel=2 -> rest of packet stays on ch1; next packet on ch2.
REQ-037 sel_latched=3 (out of range), two 3-beat packets -> s_tready=1 throughout, m_tvalid=0, drop_count=2.
REQ-038 m_tready[1]=0 for 5 cycles during a ch1 packet -> s_tready=0 after one beat is held, no data lost or duplicated, sequence intact after release.
REQ-039 Back-to-back single-beat packets with sel toggling 0/2 each cycle (clken=1) -> each beat on the channel latched before its acceptance, m_tlast=1 per beat.
REQ-040 rst pulse during beat 2 of a 4-beat packet -> outputs cleared immediately, drop_count=0, next packet routed to ch0.
